// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frame sequencer: config word, N-sample load, N-sample unload, done
module fft_frame_sequencer #(
    parameter int LOG2_N = 12,
    parameter int DATA_W = 64
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                start,
    input  logic                cfg_fwd_inv,
    input  logic [2*LOG2_N-1:0] cfg_scale_sch,
    output logic                busy,
    output logic                done,
    output logic                err_tlast_unexpected,
    output logic                err_tlast_missing,
    input  logic [DATA_W-1:0]   in_tdata,
    input  logic                in_tvalid,
    output logic                in_tready,
    output logic [2*LOG2_N:0]   fft_cfg_tdata,
    output logic                fft_cfg_tvalid,
    input  logic                fft_cfg_tready,
    output logic [DATA_W-1:0]   fft_din_tdata,
    output logic                fft_din_tvalid,
    input  logic                fft_din_tready,
    output logic                fft_din_tlast,
    input  logic [DATA_W-1:0]   fft_dout_tdata,
    input  logic                fft_dout_tvalid,
    input  logic                fft_dout_tlast,
    output logic                fft_dout_tready,
    output logic [DATA_W-1:0]   out_tdata,
    output logic                out_tvalid,
    input  logic                out_tready,
    output logic                out_tlast
);

    localparam logic [LOG2_N-1:0] LAST = '1;

    typedef enum logic [2:0] {IDLE, CFG, LOAD, UNLOAD, DONE} state_t;

    state_t            state;
    logic [LOG2_N-1:0] in_cnt;
    logic [LOG2_N-1:0] out_cnt;
    logic              in_hs;
    logic              out_hs;

    // Data paths are pure pass-through; only the handshakes are gated by state.
    assign fft_din_tdata   = in_tdata;
    assign fft_din_tvalid  = (state == LOAD) && in_tvalid;
    assign in_tready       = (state == LOAD) && fft_din_tready;
    assign fft_din_tlast   = (state == LOAD) && (in_cnt == LAST);
    assign out_tdata       = fft_dout_tdata;
    assign out_tvalid      = (state == UNLOAD) && fft_dout_tvalid;
    assign fft_dout_tready = (state == UNLOAD) && out_tready;
    assign out_tlast       = (state == UNLOAD) && (out_cnt == LAST);

    assign in_hs  = fft_din_tvalid && fft_din_tready;
    assign out_hs = out_tvalid && out_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state                <= IDLE;
            in_cnt               <= '0;
            out_cnt              <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            err_tlast_unexpected <= 1'b0;
            err_tlast_missing    <= 1'b0;
            fft_cfg_tvalid       <= 1'b0;
            fft_cfg_tdata        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        fft_cfg_tdata        <= {cfg_scale_sch, cfg_fwd_inv};
                        fft_cfg_tvalid       <= 1'b1;
                        err_tlast_unexpected <= 1'b0;
                        err_tlast_missing    <= 1'b0;
                        busy                 <= 1'b1;
                        state                <= CFG;
                    end
                end
                CFG: begin
                    if (fft_cfg_tready) begin
                        fft_cfg_tvalid <= 1'b0;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_hs) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == LAST) begin
                            state <= UNLOAD;
                        end
                    end
                end
                UNLOAD: begin
                    // The frame ends on our own count; core tlast is only audited.
                    if (out_hs) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt == LAST) begin
                            if (!fft_dout_tlast) begin
                                err_tlast_missing <= 1'b1;
                            end
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (fft_dout_tlast) begin
                            err_tlast_unexpected <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
